rgb_layer_mux: RTL and testbench
================================

// Module: rgb_layer_mux
// PURPOSE
//  Registered N-layer priority compositor for the VGA pixel path; successor to the fixed 2-object combinational RGB mux.
//  Picks the highest-priority visible layer each pixel tick (layer 0 = highest), with per-layer enable and frame-rate flashing.
//  Also reports which layer won and a per-frame overlap (collision) flag, e.g. ball vs hoop.
//  Sits between the object pixel generators and the VGA RGB output register.
// PARAMETERS
//  NUM_LAYERS  4       number of object layers, >=2
//  RGB_W       12      bits per layer colour (4:4:4)
//  BG_RGB      12'h000 colour when video_on=1 and no layer visible (RGB_W bits)
//  FLASH_DIV   30      frames per flash half-period, >=1
//  IDX_W       $clog2(NUM_LAYERS) winning-index width (min 1)
// PORTS
//  clk         in   1                  system clock
//  reset_n     in   1                  asynchronous, active-low reset
//  pixel_tick  in   1                  pixel-rate enable; all pixel state advances only when 1
//  video_on    in   1                  inside visible area (aligned with layer inputs)
//  frame_tick  in   1                  1-clk pulse at start of each frame
//  layer_on    in   NUM_LAYERS         per-layer pixel hit, bit i = layer i
//  layer_rgb   in   NUM_LAYERS*RGB_W   layer i colour at [i*RGB_W +: RGB_W]
//  layer_en    in   NUM_LAYERS         static enable mask; 0 = layer ignored everywhere
//  flash_mask  in   NUM_LAYERS         1 = layer hidden while flash_phase=1
//  rgb         out  RGB_W              registered composited pixel
//  top_idx     out  IDX_W              registered index of winning layer
//  top_valid   out  1                  registered: a layer won this pixel
//  flash_phase out  1                  current flash phase
//  collision   out  1                  >=2 layers overlapped in the previous complete frame
// BEHAVIOUR
//  Reset (reset_n=0, async): rgb=0, top_idx=0, top_valid=0, flash_phase=0,
//    frame counter=0, overlap accumulator=0, collision=0. Clears immediately and takes effect mid-line/mid-frame.
//  visible[i] = layer_on[i] & layer_en[i] & ~(flash_mask[i] & flash_phase).
//  Pixel stage: registers update only on clk edges with pixel_tick=1; otherwise they hold. Latency 1 pixel tick.
//    video_on=0             -> rgb=0, top_valid=0, top_idx=0 (blanking overrides everything).
//    any visible            -> rgb=layer_rgb of lowest i visible, top_idx=i, top_valid=1.
//    none visible           -> rgb=BG_RGB, top_valid=0, top_idx=0.
//  Hidden/disabled layers are transparent: lower-priority layers show through.
//  Flash: counter advances on each frame_tick. At FLASH_DIV-1 it wraps to 0 and
//    flash_phase toggles. FLASH_DIV=1 toggles every frame. Independent of pixel_tick.
//  Collision: on a clk edge with pixel_tick & video_on and popcount(visible)>=2,
//    set the accumulator. On frame_tick: collision <= acc | (current qualifying overlap), acc <= 0.
//    If frame_tick and an overlap pixel occur on the same edge, that overlap counts for the frame being closed.
//    collision holds for the whole following frame.
//  Flash-hidden layers never count toward collision. Disabled layers never count.
//  All arithmetic unsigned. Counter width is $clog2(FLASH_DIV)+1. No combinational path from inputs to outputs.
// TESTING
//  T1 priority: NUM_LAYERS=4, on=4'b0110, rgb1=12'hF00, rgb2=12'h0F0, video_on=1, tick
//     -> next tick rgb=12'hF00, top_idx=1, top_valid=1.
//  T2 transparency: on=4'b0110, layer_en=4'b1101 -> rgb=12'h0F0, top_idx=2;
//     on=0 -> rgb=BG_RGB, top_valid=0; video_on=0 -> rgb=12'h000.
//  T3 flash: FLASH_DIV=2, flash_mask=4'b0001, on=4'b0011. Phase toggles after frame_tick #2 and #4;
//     while flash_phase=1, rgb=layer1 colour.
//  T4 collision: frame A has one pixel with on=4'b0011; frame B has none
//     -> collision=1 after A's closing frame_tick, 0 after B's. Overlap on the same edge as frame_tick counts for A.
//  T5 stall: pixel_tick=0 for 5 clks with changing inputs -> rgb/top_idx/acc unchanged.
//  T6 reset mid-frame: assert reset_n=0 with collision=1, flash_phase=1, rgb!=0
//     -> all outputs 0 asynchronously; counter restarts, so the next toggle is FLASH_DIV frames later.

Source files
------------

// File: rtl/rgb_layer_mux.sv
// Registered N-layer priority compositor for the VGA pixel path: picks the
// highest-priority visible layer per pixel tick and tracks per-frame overlap.
module rgb_layer_mux #(
    parameter int                NUM_LAYERS = 4,
    parameter int                RGB_W      = 12,
    parameter logic [RGB_W-1:0]  BG_RGB     = '0,
    parameter int                FLASH_DIV  = 30,
    parameter int                IDX_W      = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        pixel_tick,
    input  logic                        video_on,
    input  logic                        frame_tick,
    input  logic [NUM_LAYERS-1:0]       layer_on,
    input  logic [NUM_LAYERS*RGB_W-1:0] layer_rgb,
    input  logic [NUM_LAYERS-1:0]       layer_en,
    input  logic [NUM_LAYERS-1:0]       flash_mask,
    output logic [RGB_W-1:0]            rgb,
    output logic [IDX_W-1:0]            top_idx,
    output logic                        top_valid,
    output logic                        flash_phase,
    output logic                        collision
);

    localparam int CNT_W = $clog2(FLASH_DIV) + 1;
    localparam int VC_W  = $clog2(NUM_LAYERS + 1);

    logic [NUM_LAYERS-1:0] visible;
    logic                  win_found;
    logic [IDX_W-1:0]      win_idx;
    logic [RGB_W-1:0]      win_rgb;
    logic [VC_W-1:0]       vis_count;
    logic                  overlap_px;
    logic [CNT_W-1:0]      flash_cnt;
    logic                  overlap_acc;

    assign visible = layer_on & layer_en & ~(flash_mask & {NUM_LAYERS{flash_phase}});

    // Scan from lowest priority upward so the lowest visible index wins last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_rgb   = BG_RGB;
        vis_count = '0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            vis_count = vis_count + VC_W'(visible[i]);
            if (visible[i]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(i);
                win_rgb   = layer_rgb[i*RGB_W +: RGB_W];
            end
        end
    end

    assign overlap_px = pixel_tick & video_on & (vis_count >= VC_W'(2));

    // Output qualifier: top_valid=1 means top_idx names the layer that produced
    // rgb; the whole pixel stage only moves on cycles where pixel_tick=1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rgb       <= '0;
            top_idx   <= '0;
            top_valid <= 1'b0;
        end else if (pixel_tick) begin
            if (!video_on) begin
                rgb       <= '0;
                top_idx   <= '0;
                top_valid <= 1'b0;
            end else begin
                rgb       <= win_rgb;
                top_idx   <= win_idx;
                top_valid <= win_found;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flash_cnt   <= '0;
            flash_phase <= 1'b0;
        end else if (frame_tick) begin
            if (flash_cnt == CNT_W'(FLASH_DIV - 1)) begin
                flash_cnt   <= '0;
                flash_phase <= ~flash_phase;
            end else begin
                flash_cnt <= flash_cnt + 1'b1;
            end
        end
    end

    // An overlap on the frame_tick edge belongs to the frame being closed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overlap_acc <= 1'b0;
            collision   <= 1'b0;
        end else if (frame_tick) begin
            collision   <= overlap_acc | overlap_px;
            overlap_acc <= 1'b0;
        end else if (overlap_px) begin
            overlap_acc <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rgb_layer_mux.sv
// Randomised and directed bench for rgb_layer_mux: a frame-level reference model
// queues the expected outputs, a monitor pops and compares after each clock edge.
module tb_rgb_layer_mux;

    localparam int NL = 4;
    localparam int RW = 12;
    localparam int FD = 2;
    localparam logic [RW-1:0] BG = 12'h123;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            pixel_tick, video_on, frame_tick;
    logic [NL-1:0]   layer_on, layer_en, flash_mask;
    logic [NL*RW-1:0] layer_rgb;
    logic [RW-1:0]   rgb;
    logic [1:0]      top_idx;
    logic            top_valid, flash_phase, collision;

    rgb_layer_mux #(
        .NUM_LAYERS(NL), .RGB_W(RW), .BG_RGB(BG), .FLASH_DIV(FD)
    ) dut (
        .clk(clk), .reset_n(reset_n), .pixel_tick(pixel_tick), .video_on(video_on),
        .frame_tick(frame_tick), .layer_on(layer_on), .layer_rgb(layer_rgb),
        .layer_en(layer_en), .flash_mask(flash_mask), .rgb(rgb), .top_idx(top_idx),
        .top_valid(top_valid), .flash_phase(flash_phase), .collision(collision)
    );

    always #5 clk = ~clk;

    // {collision, flash_phase, top_valid, top_idx, rgb}
    logic [16:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    // Reference state, kept in frame/pixel terms
    int          m_frames;
    logic        m_ov, m_coll, m_tv;
    logic [1:0]  m_idx;
    logic [RW-1:0] m_rgb;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_frames = 0; m_ov = 1'b0; m_coll = 1'b0;
        m_tv = 1'b0; m_idx = '0; m_rgb = '0;
    endtask

    task automatic cycle(input logic pt, input logic vo, input logic ft,
                         input logic [NL-1:0] on, input logic [NL-1:0] en,
                         input logic [NL-1:0] fm, input logic [NL*RW-1:0] rgbs);
        logic [NL-1:0] vis;
        logic          phase_now, ov;
        @(negedge clk);
        pixel_tick = pt; video_on = vo; frame_tick = ft;
        layer_on = on; layer_en = en; flash_mask = fm; layer_rgb = rgbs;
        phase_now = ((m_frames / FD) % 2) == 1;
        vis = on & en;
        if (phase_now) vis = vis & ~fm;
        if (pt) begin
            m_tv = 1'b0; m_idx = '0;
            m_rgb = vo ? BG : '0;
            if (vo) begin
                for (int i = 0; i < NL; i++) begin
                    if (vis[i]) begin
                        m_tv = 1'b1; m_idx = 2'(i); m_rgb = rgbs[i*RW +: RW];
                        break;
                    end
                end
            end
        end
        ov = pt && vo && ($countones(vis) >= 2);
        if (ft) begin
            m_coll = m_ov | ov; m_ov = 1'b0; m_frames++;
        end else if (ov) begin
            m_ov = 1'b1;
        end
        exp_q.push_back({m_coll, ((m_frames / FD) % 2) == 1, m_tv, m_idx, m_rgb});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rgb"}, 32'(rgb), 32'h0);
        check({tag, "_top_idx"}, 32'(top_idx), 32'h0);
        check({tag, "_top_valid"}, 32'(top_valid), 32'h0);
        check({tag, "_flash_phase"}, 32'(flash_phase), 32'h0);
        check({tag, "_collision"}, 32'(collision), 32'h0);
    endtask

    // Monitor: one expected entry per clock edge the stimulus has driven
    initial begin
        logic [16:0] e;
        forever begin
            @(posedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                #1;
                check("rgb", 32'(rgb), 32'(e[11:0]));
                check("top_idx", 32'(top_idx), 32'(e[13:12]));
                check("top_valid", 32'(top_valid), 32'(e[14]));
                check("flash_phase", 32'(flash_phase), 32'(e[15]));
                check("collision", 32'(collision), 32'(e[16]));
            end
        end
    end

    localparam logic [NL*RW-1:0] RGBS_A = {12'h00F, 12'h0F0, 12'hF00, 12'h0AA};

    initial begin
        logic [NL*RW-1:0] r;
        reset_n = 1'b0;
        pixel_tick = 0; video_on = 0; frame_tick = 0;
        layer_on = '0; layer_en = '0; flash_mask = '0; layer_rgb = '0;
        model_reset();
        #3;
        check_reset_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Priority, then transparency of a disabled layer, background, blanking
        cycle(1, 1, 0, 4'b0110, 4'b1111, 4'b0000, RGBS_A);
        cycle(1, 1, 0, 4'b0110, 4'b1101, 4'b0000, RGBS_A);
        cycle(1, 1, 0, 4'b0000, 4'b1111, 4'b0000, RGBS_A);
        cycle(1, 0, 0, 4'b1111, 4'b1111, 4'b0000, RGBS_A);

        // Flash phase: toggles after frame_tick #2 and #4, layer 0 hidden in phase 1
        for (int f = 0; f < 5; f++) begin
            cycle(1, 1, 0, 4'b0011, 4'b1111, 4'b0001, RGBS_A);
            cycle(0, 1, 1, 4'b0011, 4'b1111, 4'b0001, RGBS_A);
        end

        // Collision: frame A with one overlap pixel, frame B with none, same-edge case
        cycle(0, 1, 1, 4'b0000, 4'b1111, 4'b0000, RGBS_A);
        cycle(1, 1, 0, 4'b0011, 4'b1111, 4'b0000, RGBS_A);
        cycle(1, 1, 0, 4'b0001, 4'b1111, 4'b0000, RGBS_A);
        cycle(0, 1, 1, 4'b0000, 4'b1111, 4'b0000, RGBS_A);
        cycle(1, 1, 0, 4'b0100, 4'b1111, 4'b0000, RGBS_A);
        cycle(0, 1, 1, 4'b0000, 4'b1111, 4'b0000, RGBS_A);
        cycle(1, 1, 1, 4'b1100, 4'b1111, 4'b0000, RGBS_A);
        cycle(1, 1, 0, 4'b1010, 4'b0101, 4'b0000, RGBS_A);
        cycle(0, 1, 1, 4'b0000, 4'b1111, 4'b0000, RGBS_A);

        // Stall: inputs churn with pixel_tick low
        cycle(1, 1, 0, 4'b1000, 4'b1111, 4'b0000, RGBS_A);
        for (int s = 0; s < 5; s++) begin
            r = {$urandom(), $urandom()};
            cycle(0, 1'($urandom_range(0, 1)), 0, 4'($urandom()), 4'b1111, 4'b0000, r);
        end

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            r = {$urandom(), $urandom()};
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 5) != 0,
                  $urandom_range(0, 15) == 0, 4'($urandom()), 4'($urandom()) | 4'b0001,
                  4'($urandom()), r);
        end

        // Build collision=1, flash_phase=1, rgb!=0 and reset mid-frame
        model_reset_prep: begin
            cycle(0, 1, 1, 4'b0000, 4'b1111, 4'b0000, RGBS_A);
            while (((m_frames / FD) % 2) != 1)
                cycle(0, 1, 1, 4'b0000, 4'b1111, 4'b0000, RGBS_A);
            cycle(1, 1, 0, 4'b0011, 4'b1111, 4'b0000, RGBS_A);
            cycle(0, 1, 1, 4'b0000, 4'b1111, 4'b0000, RGBS_A);
            while (((m_frames / FD) % 2) != 1)
                cycle(0, 1, 1, 4'b0000, 4'b1111, 4'b0000, RGBS_A);
            cycle(1, 1, 0, 4'b0011, 4'b1111, 4'b0000, RGBS_A);
        end
        @(negedge clk);
        check("pre_reset_collision", 32'(collision), 32'(m_coll));
        check("pre_reset_phase", 32'(flash_phase), 32'h1);
        pixel_tick = 0; frame_tick = 0;
        #2 reset_n = 1'b0;
        #1;
        check_reset_outputs("midframe_reset");
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;

        // Counter restarted: phase stays 0 for FD-1 frame ticks, then flips
        for (int f = 0; f < 2 * FD + 1; f++) begin
            cycle(1, 1, 0, 4'b0011, 4'b1111, 4'b0001, RGBS_A);
            cycle(0, 1, 1, 4'b0000, 4'b1111, 4'b0001, RGBS_A);
        end
        cycle(0, 0, 0, 4'b0000, 4'b0000, 4'b0000, RGBS_A);

        @(posedge clk);
        #3;
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
